cmp_rs: RTL and testbench
=========================

Name: cmp_rs

Overview:
Reservation station feeding the OoO compare unit (slt/sltu and branch compares). Accepts dispatched compare ops from the dispatch/rename stage and holds them until both operands are valid. Snoops the CDB for missing operands and issues the oldest ready entry to the compare unit over a valid/ready handshake. Flushes on mispredict/exception.

Parameters:
DEPTH, 4, number of RS entries (power of two, >=2)
TAG_W, 3, ROB tag width
OCC_W, $clog2(DEPTH)+1, occupancy counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
flush  in  1  discard all entries
dispatch_valid  in  1  dispatch offers an op
dispatch_ready  out  1  RS can accept (occupancy < DEPTH)
dispatch_funct3  in  3  funct3 of op (slt/sltu or branch)
dispatch_rob_tag  in  TAG_W  destination ROB tag
src1_ready  in  1  src1 value valid at dispatch
src1_tag  in  TAG_W  producer tag if not ready
src1_data  in  32  src1 value if ready
src2_ready  in  1  as src1
src2_tag  in  TAG_W  as src1
src2_data  in  32  as src1
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  CDB producer tag
cdb_data  in  32  CDB value
issue_valid  out  1  op offered to compare unit
issue_ready  in  1  compare unit accepts
issue_funct3  out  3  funct3 of offered op
issue_first  out  32  operand 1
issue_second  out  32  operand 2
issue_rob_tag  out  TAG_W  ROB tag of offered op
occupancy  out  OCC_W  valid entry count

Behaviour:
- Reset (rst=0, async): all entries invalid, occupancy=0, dispatch_ready=1, issue_valid=0, issue_* data outputs 0, issue lock cleared.
- Entry fields: valid, funct3, rob_tag, per-source {rdy, tag, data}, age order.
- Dispatch: accepted at edge when dispatch_valid && dispatch_ready && !flush. dispatch_ready depends only on registered occupancy; full RS deasserts it even if an issue occurs this cycle.
- Dispatch bypass: if src not ready and cdb_valid && cdb_tag==src tag in the dispatch cycle, entry stores cdb_data with rdy=1.
- Wakeup: each cycle, every valid entry with a non-ready source whose tag == cdb_tag (cdb_valid=1) captures cdb_data, rdy=1 at the edge. Both sources of one entry may wake on the same broadcast.
- Ready entry: valid && src1.rdy && src2.rdy (registered state). Earliest issue: cycle after dispatch (1-cycle latency).
- Select: oldest ready entry by dispatch order. issue_* driven combinationally from the selected entry; zero when issue_valid=0.
- Stability: once issue_valid=1 and issue_ready=0, the offered entry is locked; issue_* hold unchanged until transfer even if an older entry becomes ready.
- Transfer: issue_valid && issue_ready at an edge frees the entry, clears lock. Dispatch and issue in the same cycle: occupancy unchanged.
- occupancy: +1 per accepted dispatch, -1 per transfer; never exceeds DEPTH or wraps below 0.
- Flush: issue_valid forced 0 in the flush cycle; at the edge all entries invalid, lock cleared, occupancy=0; concurrent dispatch and issue_ready ignored.
- funct3 passed through unmodified; no arithmetic in RS.

Optional Feature:
CMP_RS_WAKEUP_BYPASS_EN: when defined, an entry whose last missing source matches the current CDB broadcast counts as ready this cycle and may be selected, with cdb_data forwarded onto issue_first/issue_second (latency CDB->issue = 0 cycles). Lock rules unchanged. When undefined, a woken entry becomes ready only from registered state the following cycle (latency 1).

Test Plan:
- Reset: hold rst=0 two cycles -> issue_valid=0, dispatch_ready=1, occupancy=0; release, dispatch funct3=3'b010, rob_tag=2, src1=5, src2=9 both ready -> next cycle issue_valid=1, first=5, second=9, rob_tag=2.
- Wakeup: dispatch tag=1 with src1 waiting on tag 4; cdb_valid=1, tag=4, data=32'hFFFF_FFFF two cycles later -> issue_valid rises the following cycle (same cycle with _EN), issue_first=32'hFFFF_FFFF.
- Full: DEPTH=4 dispatches with waiting operands -> occupancy=4, dispatch_ready=0; 5th dispatch_valid ignored; wake one, transfer -> occupancy=3, dispatch_ready=1.
- Ordering/stability: entries A (tag0) then B (tag1); B ready first, issue_ready=0; A becomes ready -> issue_rob_tag stays 1 until transfer, then A offered next cycle.
- Flush: 3 entries, dispatch_valid=1 and flush=1 same cycle -> issue_valid=0 that cycle, next cycle occupancy=0, no stale issue.
- Async reset mid-operation: assert rst=0 between edges with 2 valid entries -> issue_valid=0, occupancy=0 immediately, before next clock edge.

Source files
------------

// File: rtl/cmp_rs.sv
// Compare-unit reservation station: holds ops until both operands are valid and issues the oldest ready op; 1-cycle dispatch->issue latency.
// Backpressure: dispatch_ready drops when full; an offered op is held stable while issue_ready is low. Optional CDB->issue bypass: CMP_RS_WAKEUP_BYPASS_EN.
module cmp_rs #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 3,
  parameter int OCC_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             dispatch_valid,
  output logic             dispatch_ready,
  input  logic [2:0]       dispatch_funct3,
  input  logic [TAG_W-1:0] dispatch_rob_tag,
  input  logic             src1_ready,
  input  logic [TAG_W-1:0] src1_tag,
  input  logic [31:0]      src1_data,
  input  logic             src2_ready,
  input  logic [TAG_W-1:0] src2_tag,
  input  logic [31:0]      src2_data,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [2:0]       issue_funct3,
  output logic [31:0]      issue_first,
  output logic [31:0]      issue_second,
  output logic [TAG_W-1:0] issue_rob_tag,
  output logic [OCC_W-1:0] occupancy
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic             rdy;
    logic [TAG_W-1:0] tag;
    logic [31:0]      dat;
  } src_t;

  typedef struct packed {
    logic             vld;
    logic [2:0]       funct3;
    logic [TAG_W-1:0] rob_tag;
    src_t             s1;
    src_t             s2;
  } ent_t;

  ent_t             ent_q   [DEPTH];
  ent_t             ent_d   [DEPTH];
  // older_q[i][j] set means entry j was dispatched before entry i
  logic [DEPTH-1:0] older_q [DEPTH];
  logic [DEPTH-1:0] older_d [DEPTH];
  logic             lock_q, lock_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  logic [DEPTH-1:0] vld_vec, rdy1_vec, rdy2_vec, rdy_vec;
  logic [31:0]      op1_dat [DEPTH];
  logic [31:0]      op2_dat [DEPTH];
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] free_idx;
  logic             disp_fire, xfer;
  src_t             new_s1, new_s2;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      vld_vec[i]  = ent_q[i].vld;
      rdy1_vec[i] = ent_q[i].s1.rdy;
      rdy2_vec[i] = ent_q[i].s2.rdy;
      op1_dat[i]  = ent_q[i].s1.dat;
      op2_dat[i]  = ent_q[i].s2.dat;
`ifdef CMP_RS_WAKEUP_BYPASS_EN
      if (cdb_valid && !ent_q[i].s1.rdy && ent_q[i].s1.tag == cdb_tag) begin
        rdy1_vec[i] = 1'b1;
        op1_dat[i]  = cdb_data;
      end
      if (cdb_valid && !ent_q[i].s2.rdy && ent_q[i].s2.tag == cdb_tag) begin
        rdy2_vec[i] = 1'b1;
        op2_dat[i]  = cdb_data;
      end
`endif
    end
    rdy_vec = vld_vec & rdy1_vec & rdy2_vec;
  end

  // A locked entry stays ready: sources never lose readiness once gained.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    if (lock_q) begin
      sel_found = ent_q[lock_idx_q].vld;
      sel_idx   = lock_idx_q;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy_vec[i] && ((older_q[i] & rdy_vec) == '0)) begin
          sel_found = 1'b1;
          sel_idx   = i[IDX_W-1:0];
        end
      end
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent_q[i].vld) free_idx = i[IDX_W-1:0];
    end
  end

  assign dispatch_ready = (occ_q < OCC_W'(DEPTH));
  assign occupancy      = occ_q;
  assign issue_valid    = sel_found && !flush;
  assign issue_funct3   = issue_valid ? ent_q[sel_idx].funct3  : '0;
  assign issue_rob_tag  = issue_valid ? ent_q[sel_idx].rob_tag : '0;
  assign issue_first    = issue_valid ? op1_dat[sel_idx]       : '0;
  assign issue_second   = issue_valid ? op2_dat[sel_idx]       : '0;

  assign disp_fire = dispatch_valid && dispatch_ready && !flush;
  assign xfer      = issue_valid && issue_ready;

  always_comb begin
    new_s1.tag = src1_tag;
    new_s1.rdy = src1_ready || (cdb_valid && cdb_tag == src1_tag);
    new_s1.dat = src1_ready ? src1_data : (new_s1.rdy ? cdb_data : '0);
    new_s2.tag = src2_tag;
    new_s2.rdy = src2_ready || (cdb_valid && cdb_tag == src2_tag);
    new_s2.dat = src2_ready ? src2_data : (new_s2.rdy ? cdb_data : '0);
  end

  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    occ_d      = occ_q;
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i]   = ent_q[i];
      older_d[i] = older_q[i];
      if (cdb_valid && ent_q[i].vld) begin
        if (!ent_q[i].s1.rdy && ent_q[i].s1.tag == cdb_tag) begin
          ent_d[i].s1.rdy = 1'b1;
          ent_d[i].s1.dat = cdb_data;
        end
        if (!ent_q[i].s2.rdy && ent_q[i].s2.tag == cdb_tag) begin
          ent_d[i].s2.rdy = 1'b1;
          ent_d[i].s2.dat = cdb_data;
        end
      end
    end

    if (xfer) begin
      ent_d[sel_idx].vld = 1'b0;
      lock_d             = 1'b0;
    end else if (issue_valid) begin
      lock_d     = 1'b1;
      lock_idx_d = sel_idx;
    end

    if (disp_fire) begin
      ent_d[free_idx].vld     = 1'b1;
      ent_d[free_idx].funct3  = dispatch_funct3;
      ent_d[free_idx].rob_tag = dispatch_rob_tag;
      ent_d[free_idx].s1      = new_s1;
      ent_d[free_idx].s2      = new_s2;
      older_d[free_idx]       = vld_vec;
      for (int i = 0; i < DEPTH; i++) older_d[i][free_idx] = 1'b0;
    end

    case ({disp_fire, xfer})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i].vld = 1'b0;
      lock_d = 1'b0;
      occ_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i]   <= '0;
        older_q[i] <= '0;
      end
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      occ_q      <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i]   <= ent_d[i];
        older_q[i] <= older_d[i];
      end
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      occ_q      <= occ_d;
    end
  end

endmodule

// File: tb/tb_cmp_rs.sv
// Bench for cmp_rs: directed scenarios plus random traffic, checked against a queue model in dispatch order.
module tb_cmp_rs;
  localparam int DEPTH = 4;
  localparam int TAG_W = 3;
  localparam int OCC_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             dispatch_valid;
  logic             dispatch_ready;
  logic [2:0]       dispatch_funct3;
  logic [TAG_W-1:0] dispatch_rob_tag;
  logic             src1_ready, src2_ready;
  logic [TAG_W-1:0] src1_tag, src2_tag;
  logic [31:0]      src1_data, src2_data;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;
  logic             issue_valid;
  logic             issue_ready;
  logic [2:0]       issue_funct3;
  logic [31:0]      issue_first, issue_second;
  logic [TAG_W-1:0] issue_rob_tag;
  logic [OCC_W-1:0] occupancy;

  cmp_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W), .OCC_W(OCC_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_funct3(dispatch_funct3), .dispatch_rob_tag(dispatch_rob_tag),
    .src1_ready(src1_ready), .src1_tag(src1_tag), .src1_data(src1_data),
    .src2_ready(src2_ready), .src2_tag(src2_tag), .src2_data(src2_data),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_funct3(issue_funct3), .issue_first(issue_first),
    .issue_second(issue_second), .issue_rob_tag(issue_rob_tag),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               id;
    logic [2:0]       f3;
    logic [TAG_W-1:0] rob;
    bit               r1;
    logic [TAG_W-1:0] t1;
    logic [31:0]      d1;
    bit               r2;
    logic [TAG_W-1:0] t2;
    logic [31:0]      d2;
  } m_ent_t;

  m_ent_t      mq[$];
  bit          m_lock;
  int          m_lock_id;
  int          next_id;
  int          exp_idx;
  bit          e_valid;
  logic [2:0]  e_f3;
  logic [31:0] e_first, e_second;
  logic [TAG_W-1:0] e_rob;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic bit cdb_hit(bit r, logic [TAG_W-1:0] t);
`ifdef CMP_RS_WAKEUP_BYPASS_EN
    return !r && cdb_valid && cdb_tag == t;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_ready(m_ent_t e);
    return (e.r1 || cdb_hit(e.r1, e.t1)) && (e.r2 || cdb_hit(e.r2, e.t2));
  endfunction

  task automatic model_reset();
    mq.delete();
    m_lock = 1'b0;
  endtask

  task automatic model_expect();
    m_ent_t e;
    exp_idx = -1;
    if (m_lock) begin
      foreach (mq[i]) if (mq[i].id == m_lock_id) exp_idx = i;
    end else begin
      for (int i = mq.size() - 1; i >= 0; i--) if (m_ready(mq[i])) exp_idx = i;
    end
    e_valid = (exp_idx >= 0) && !flush;
    e_f3 = '0; e_first = '0; e_second = '0; e_rob = '0;
    if (e_valid) begin
      e = mq[exp_idx];
      e_f3     = e.f3;
      e_rob    = e.rob;
      e_first  = e.r1 ? e.d1 : cdb_data;
      e_second = e.r2 ? e.d2 : cdb_data;
    end
  endtask

  task automatic model_edge();
    bit acc;
    m_ent_t e;
    acc = dispatch_valid && !flush && (mq.size() < DEPTH);
    if (flush) begin
      model_reset();
      return;
    end
    if (e_valid && issue_ready) begin
      mq.delete(exp_idx);
      m_lock = 1'b0;
    end else if (e_valid) begin
      m_lock    = 1'b1;
      m_lock_id = mq[exp_idx].id;
    end
    if (cdb_valid) begin
      foreach (mq[i]) begin
        e = mq[i];
        if (!e.r1 && e.t1 == cdb_tag) begin e.r1 = 1'b1; e.d1 = cdb_data; end
        if (!e.r2 && e.t2 == cdb_tag) begin e.r2 = 1'b1; e.d2 = cdb_data; end
        mq[i] = e;
      end
    end
    if (acc) begin
      e.id  = next_id++;
      e.f3  = dispatch_funct3;
      e.rob = dispatch_rob_tag;
      e.t1  = src1_tag;
      e.t2  = src2_tag;
      e.r1  = src1_ready || (cdb_valid && cdb_tag == src1_tag);
      e.d1  = src1_ready ? src1_data : cdb_data;
      e.r2  = src2_ready || (cdb_valid && cdb_tag == src2_tag);
      e.d2  = src2_ready ? src2_data : cdb_data;
      mq.push_back(e);
    end
  endtask

  // Compare against the model shortly after the inputs settle, then advance one clock.
  task automatic cycle();
    #1;
    model_expect();
    check("issue_valid",    64'(issue_valid),    64'(e_valid));
    check("issue_funct3",   64'(issue_funct3),   64'(e_f3));
    check("issue_first",    64'(issue_first),    64'(e_first));
    check("issue_second",   64'(issue_second),   64'(e_second));
    check("issue_rob_tag",  64'(issue_rob_tag),  64'(e_rob));
    check("occupancy",      64'(occupancy),      64'(mq.size()));
    check("dispatch_ready", 64'(dispatch_ready), 64'(mq.size() < DEPTH));
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    flush = 0; dispatch_valid = 0; dispatch_funct3 = '0; dispatch_rob_tag = '0;
    src1_ready = 0; src1_tag = '0; src1_data = '0;
    src2_ready = 0; src2_tag = '0; src2_data = '0;
    cdb_valid = 0; cdb_tag = '0; cdb_data = '0; issue_ready = 0;
  endtask

  task automatic disp(input logic [2:0] f3, input logic [TAG_W-1:0] rob,
                      input bit r1, input logic [TAG_W-1:0] t1, input logic [31:0] d1,
                      input bit r2, input logic [TAG_W-1:0] t2, input logic [31:0] d2);
    dispatch_valid = 1; dispatch_funct3 = f3; dispatch_rob_tag = rob;
    src1_ready = r1; src1_tag = t1; src1_data = d1;
    src2_ready = r2; src2_tag = t2; src2_data = d2;
  endtask

  task automatic cdb(input logic [TAG_W-1:0] t, input logic [31:0] d);
    cdb_valid = 1; cdb_tag = t; cdb_data = d;
  endtask

  task automatic drain();
    idle();
    for (int k = 0; k < 8; k++) begin
      cdb(TAG_W'(k), 32'hD000_0000 + 32'(k));
      issue_ready = 1;
      cycle();
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      issue_ready = 1;
      cycle();
    end
    idle();
  endtask

  initial begin
    idle();
    model_reset();
    next_id = 0;
    rst = 0;
    #1;
    check("rst_issue_valid", 64'(issue_valid), 64'(0));
    check("rst_dispatch_ready", 64'(dispatch_ready), 64'(1));
    check("rst_occupancy", 64'(occupancy), 64'(0));
    @(negedge clk); @(negedge clk);
    check("rst2_issue_valid", 64'(issue_valid), 64'(0));
    rst = 1;

    // Both operands ready at dispatch: offered the next cycle.
    disp(3'b010, 3'd2, 1, 3'd0, 32'd5, 1, 3'd0, 32'd9);
    cycle();
    idle();
    #1;
    check("t1_valid", 64'(issue_valid), 64'(1));
    check("t1_first", 64'(issue_first), 64'(5));
    check("t1_second", 64'(issue_second), 64'(9));
    check("t1_rob", 64'(issue_rob_tag), 64'(2));
    check("t1_funct3", 64'(issue_funct3), 64'(3'b010));
    cycle();
    drain();

    // Wakeup of src1 via CDB two cycles after dispatch.
    disp(3'b000, 3'd1, 0, 3'd4, 32'd0, 1, 3'd0, 32'd7);
    cycle();
    idle();
    cycle();
    cdb(3'd4, 32'hFFFF_FFFF);
    #1;
`ifdef CMP_RS_WAKEUP_BYPASS_EN
    check("wk_same_cycle_valid", 64'(issue_valid), 64'(1));
    check("wk_same_cycle_first", 64'(issue_first), 64'(32'hFFFF_FFFF));
`else
    check("wk_not_yet_valid", 64'(issue_valid), 64'(0));
`endif
    cycle();
    idle();
    #1;
    check("wk_valid", 64'(issue_valid), 64'(1));
    check("wk_first", 64'(issue_first), 64'(32'hFFFF_FFFF));
    check("wk_second", 64'(issue_second), 64'(7));
    issue_ready = 1;
    cycle();
    drain();

    // Fill all entries with waiting operands, then a fifth dispatch.
    for (int k = 0; k < DEPTH; k++) begin
      disp(3'b100, TAG_W'(k), 0, TAG_W'(k), 32'd0, 1, 3'd0, 32'(100 + k));
      cycle();
    end
    idle();
    #1;
    check("full_occ", 64'(occupancy), 64'(4));
    check("full_ready", 64'(dispatch_ready), 64'(0));
    disp(3'b101, 3'd7, 1, 3'd0, 32'd1, 1, 3'd0, 32'd2);
    cycle();
    idle();
    #1;
    check("full_5th_ignored", 64'(occupancy), 64'(4));
    cdb(3'd2, 32'h1234);
    cycle();
    idle();
    issue_ready = 1;
    cycle();
    idle();
    #1;
    check("full_after_xfer_occ", 64'(occupancy), 64'(3));
    check("full_after_xfer_ready", 64'(dispatch_ready), 64'(1));
    drain();

    // Younger entry offered first stays offered after the older one becomes ready.
    disp(3'b001, 3'd0, 0, 3'd6, 32'd0, 1, 3'd0, 32'd11);
    cycle();
    disp(3'b001, 3'd1, 0, 3'd7, 32'd0, 1, 3'd0, 32'd22);
    cycle();
    idle();
    cdb(3'd7, 32'hB);
    cycle();
    idle();
    cdb(3'd6, 32'hA);
    #1;
    check("ord_locked_b", 64'(issue_rob_tag), 64'(1));
    cycle();
    idle();
    #1;
    check("ord_still_b", 64'(issue_rob_tag), 64'(1));
    issue_ready = 1;
    cycle();
    idle();
    #1;
    check("ord_then_a_valid", 64'(issue_valid), 64'(1));
    check("ord_then_a", 64'(issue_rob_tag), 64'(0));
    check("ord_then_a_first", 64'(issue_first), 64'(32'hA));
    drain();

    // Flush with a concurrent dispatch.
    disp(3'b110, 3'd3, 1, 3'd0, 32'd1, 1, 3'd0, 32'd2);
    cycle();
    disp(3'b110, 3'd4, 0, 3'd1, 32'd0, 1, 3'd0, 32'd2);
    cycle();
    disp(3'b110, 3'd5, 0, 3'd2, 32'd0, 1, 3'd0, 32'd2);
    cycle();
    disp(3'b111, 3'd6, 1, 3'd0, 32'd3, 1, 3'd0, 32'd4);
    flush = 1;
    issue_ready = 1;
    #1;
    check("flush_issue_low", 64'(issue_valid), 64'(0));
    cycle();
    idle();
    #1;
    check("flush_occ", 64'(occupancy), 64'(0));
    check("flush_no_stale", 64'(issue_valid), 64'(0));
    cdb(3'd1, 32'h55);
    cycle();
    idle();
    cycle();

    // Asynchronous reset between edges.
    disp(3'b010, 3'd1, 1, 3'd0, 32'd8, 1, 3'd0, 32'd9);
    cycle();
    disp(3'b010, 3'd2, 0, 3'd3, 32'd0, 1, 3'd0, 32'd9);
    cycle();
    idle();
    #2;
    rst = 0;
    #1;
    check("arst_issue_valid", 64'(issue_valid), 64'(0));
    check("arst_occ", 64'(occupancy), 64'(0));
    model_reset();
    @(negedge clk);
    rst = 1;

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      idle();
      if ($urandom_range(0, 99) < 60)
        disp(3'($urandom), 3'($urandom),
             $urandom_range(0, 1) == 1, 3'($urandom), $urandom,
             $urandom_range(0, 1) == 1, 3'($urandom), $urandom);
      if ($urandom_range(0, 99) < 50) cdb(3'($urandom), $urandom);
      issue_ready = ($urandom_range(0, 99) < 55);
      flush = ($urandom_range(0, 99) < 3);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
